// File: rtl/axi_mon_pkg.sv
// Shared types for the AXI monitor recovery path.
// State encoding and cause bit positions.
package axi_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    DRAIN,
    RESET,
    WAIT_ACK
  } recovery_state_e;

  localparam int CauseRd = 0;
  localparam int CauseWr = 1;

endpackage

// File: rtl/mon_cycle_cnt.sv
// Clearable up counter with terminal-count compare.
// One instance times both DRAIN and RESET.
module mon_cycle_cnt #(
  parameter int Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] term_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;
  assign tc_o  = (r_cnt == term_i);

endmodule

// File: rtl/axi_mon_recovery_ctrl.sv
// Recovery sequencer: isolate, drain, reset subordinate,
// clear txn tables, then interrupt until software acks.
module axi_mon_recovery_ctrl
  import axi_mon_pkg::*;
#(
  parameter int DrainCycles   = 256,
  parameter int RstHoldCycles = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rd_reset_req_i,
  input  logic       wr_reset_req_i,
  input  logic       rd_busy_i,
  input  logic       wr_busy_i,
  input  logic       irq_ack_i,
  output logic       isolate_o,
  output logic       slv_rst_no,
  output logic       tbl_clr_o,
  output logic       irq_o,
  output logic [1:0] cause_o,
  output logic       drain_forced_o,
  output logic       busy_o
);

  localparam int CntMax =
    (DrainCycles > RstHoldCycles) ? DrainCycles : RstHoldCycles;
  localparam int CntW = $clog2(CntMax) + 1;

  recovery_state_e r_state;
  recovery_state_e w_state_nxt;
  logic [1:0]      r_cause;
  logic [1:0]      w_cause_nxt;
  logic            r_forced;
  logic            w_forced_nxt;
  logic [1:0]      w_req;
  logic            w_busy_any;
  logic            w_clr;
  logic            w_en;
  logic            w_tc;
  logic [CntW-1:0] w_term;
  logic [CntW-1:0] w_cnt;

  assign w_req[CauseRd] = rd_reset_req_i;
  assign w_req[CauseWr] = wr_reset_req_i;
  assign w_busy_any     = rd_busy_i | wr_busy_i;

  // Counter restarts on every state entry, so it never wraps.
  assign w_clr  = (w_state_nxt != r_state);
  assign w_en   = (r_state == DRAIN) || (r_state == RESET);
  assign w_term = (r_state == DRAIN) ? CntW'(DrainCycles - 1)
                                     : CntW'(RstHoldCycles - 1);

  mon_cycle_cnt #(
    .Width (CntW)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_clr),
    .en_i   (w_en),
    .term_i (w_term),
    .cnt_o  (w_cnt),
    .tc_o   (w_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cause  <= '0;
      r_forced <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cause  <= w_cause_nxt;
      r_forced <= w_forced_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cause_nxt  = r_cause;
    w_forced_nxt = r_forced;
    unique case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_state_nxt = ISOLATE;
          w_cause_nxt = r_cause | w_req;
        end
      end
      ISOLATE: begin
        w_state_nxt = DRAIN;
        w_cause_nxt = r_cause | w_req;
      end
      DRAIN: begin
        w_cause_nxt = r_cause | w_req;
        if (!w_busy_any) begin
          w_state_nxt = RESET;
        end else if (w_tc) begin
          w_state_nxt  = RESET;
          w_forced_nxt = 1'b1;
        end
      end
      // Requests are dropped while the tables are being cleared.
      RESET: begin
        if (w_tc) begin
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (irq_ack_i) begin
          w_forced_nxt = 1'b0;
          w_cause_nxt  = w_req;
          w_state_nxt  = (|w_req) ? ISOLATE : IDLE;
        end else begin
          w_cause_nxt = r_cause | w_req;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign isolate_o      = (r_state != IDLE);
  assign busy_o         = (r_state != IDLE);
  assign slv_rst_no     = (r_state != RESET);
  assign tbl_clr_o      = (r_state == RESET) && (w_cnt == '0);
  assign irq_o          = (r_state == WAIT_ACK);
  assign cause_o        = r_cause;
  assign drain_forced_o = r_forced;

endmodule

// File: tb/tb_axi_mon_recovery_ctrl.sv
// Directed bench for axi_mon_recovery_ctrl with a
// phase/countdown reference model checked every cycle.
module tb_axi_mon_recovery_ctrl;

  localparam int DrainCycles   = 256;
  localparam int RstHoldCycles = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_busy = 1'b0;
  logic       wr_busy = 1'b0;
  logic       ack = 1'b0;
  logic       isolate;
  logic       slv_rst_n;
  logic       tbl_clr;
  logic       irq;
  logic [1:0] cause;
  logic       forced;
  logic       busy;

  int tests = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  axi_mon_recovery_ctrl #(
    .DrainCycles   (DrainCycles),
    .RstHoldCycles (RstHoldCycles)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rd_reset_req_i (rd_req),
    .wr_reset_req_i (wr_req),
    .rd_busy_i      (rd_busy),
    .wr_busy_i      (wr_busy),
    .irq_ack_i      (ack),
    .isolate_o      (isolate),
    .slv_rst_no     (slv_rst_n),
    .tbl_clr_o      (tbl_clr),
    .irq_o          (irq),
    .cause_o        (cause),
    .drain_forced_o (forced),
    .busy_o         (busy)
  );

  // Model: 0 idle, 1 isolate, 2 drain, 3 subordinate reset, 4 wait ack.
  // m_left counts cycles remaining in the timed phases.
  int         m_phase;
  int         m_left;
  logic [1:0] m_cause;
  logic       m_forced;

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] req;
    req = {wr_req, rd_req};
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_cause = 0; m_forced = 0;
    end else begin
      case (m_phase)
        0: if (req != 0) begin m_phase = 1; m_cause = m_cause | req; end
        1: begin m_phase = 2; m_left = DrainCycles; m_cause = m_cause | req; end
        2: begin
          m_cause = m_cause | req;
          if (!(rd_busy || wr_busy)) begin
            m_phase = 3; m_left = RstHoldCycles;
          end else if (m_left == 1) begin
            m_phase = 3; m_left = RstHoldCycles; m_forced = 1;
          end else m_left--;
        end
        3: if (m_left == 1) m_phase = 4; else m_left--;
        default: begin
          if (ack) begin
            m_forced = 0; m_cause = req;
            m_phase = (req != 0) ? 1 : 0;
          end else m_cause = m_cause | req;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_v, got_v;
    exp_v = {m_phase != 0, m_phase != 3,
             (m_phase == 3) && (m_left == RstHoldCycles),
             m_phase == 4, m_cause, m_forced, m_phase != 0};
    got_v = {isolate, slv_rst_n, tbl_clr, irq, cause, forced, busy};
    tests++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, got_v, exp_v);
    end
    if (tbl_clr === 1'b1) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    int p0;
    #1;
    chk("reset_outs", {isolate, slv_rst_n, tbl_clr, irq, cause, forced, busy},
        8'b0100_0000);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Read request, subordinate idle
    rd_req = 1; tick(); rd_req = 0;
    chk("t1_isolate_c1", 8'(isolate), 8'd1);
    tick(); tick();
    chk("t1_rst_c3", 8'(slv_rst_n), 8'd0);
    chk("t1_clr_c3", 8'(tbl_clr), 8'd1);
    tick();
    chk("t1_clr_c4", 8'(tbl_clr), 8'd0);
    repeat (14) tick();
    chk("t1_rst_c18", 8'(slv_rst_n), 8'd0);
    chk("t1_irq_c18", 8'(irq), 8'd0);
    tick();
    chk("t1_irq_c19", 8'(irq), 8'd1);
    chk("t1_rstn_c19", 8'(slv_rst_n), 8'd1);
    chk("t1_cause", 8'(cause), 8'd1);
    ack = 1; tick(); ack = 0;
    chk("t1_after_ack", {irq, busy, cause}, 8'd0);

    // Forced drain
    wr_busy = 1; wr_req = 1; tick(); wr_req = 0;
    tick();
    repeat (255) tick();
    chk("t2_drain_last", {slv_rst_n, forced}, 8'b10);
    tick();
    chk("t2_reset_entry", {slv_rst_n, forced, cause}, 8'b0110);
    repeat (15) tick();
    chk("t2_reset_last", 8'(slv_rst_n), 8'd0);
    tick();
    chk("t2_irq", 8'(irq), 8'd1);
    wr_busy = 0;
    ack = 1; tick(); ack = 0;
    chk("t2_forced_clr", 8'(forced), 8'd0);

    // Simultaneous requests, extra request absorbed in DRAIN
    p0 = pulses;
    rd_busy = 1; rd_req = 1; wr_req = 1; tick(); rd_req = 0; wr_req = 0;
    tick(); tick();
    rd_req = 1; tick(); rd_req = 0;
    tick();
    rd_busy = 0;
    repeat (40) tick();
    chk("t3_pulses", 8'(pulses - p0), 8'd1);
    chk("t3_cause", 8'(cause), 8'b11);
    chk("t3_irq", 8'(irq), 8'd1);

    // Ack coincident with a new read request
    ack = 1; rd_req = 1; tick(); ack = 0; rd_req = 0;
    chk("t4_irq", 8'(irq), 8'd0);
    chk("t4_iso", {isolate, busy}, 8'b11);
    chk("t4_cause", 8'(cause), 8'b01);

    // Async reset at RESET cycle 5
    tick(); tick();
    repeat (4) tick();
    chk("t5_in_reset", 8'(slv_rst_n), 8'd0);
    #2 rst_n = 0;
    #1;
    chk("t5_async", {slv_rst_n, isolate, busy}, 8'b100);
    tick(); rst_n = 1;
    p0 = pulses;
    repeat (5) tick();
    chk("t5_idle", {busy, irq, cause}, 8'd0);
    chk("t5_nopulse", 8'(pulses - p0), 8'd0);

    // Spurious ack in IDLE
    ack = 1; tick(); ack = 0; tick();
    chk("t6_spurious", {isolate, slv_rst_n, irq, cause, forced, busy},
        8'b0100_000);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
